// File: rtl/cohort_gearbox_pkg.sv
// cohort_gearbox_pkg
// Shared types and elaboration-time helpers for the cohort_gearbox width
// converter:
//   - beats()        : beats of a given width that make up one frame
//   - ceil_div()     : integer ceiling division (drain-beat count of a frame)
//   - idx_w()        : index width for a counter/pointer over n entries (min 1)
//   - params_legal() : parameter legality, evaluated once at elaboration
//   - slot_meta_t    : per-slot bookkeeping (committed flag + filled beats)
package cohort_gearbox_pkg;

    // Wide enough for any practical number of input beats per frame.
    localparam int CNT_W = 16;

    typedef struct packed {
        logic             committed;
        logic [CNT_W-1:0] fill_beats;
    } slot_meta_t;

    function automatic int beats(input int frame_w, input int beat_w);
        return frame_w / beat_w;
    endfunction

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_legal(input int in_w, input int out_w,
                                        input int frame_w, input int num_slots);
        if (in_w <= 0 || out_w <= 0 || frame_w <= 0) return 1'b0;
        if ((frame_w % in_w) != 0 || (frame_w % out_w) != 0) return 1'b0;
        if (num_slots != 1 && num_slots != 2) return 1'b0;
        if ((frame_w / in_w) >= (1 << CNT_W)) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/cohort_gearbox_slot_buf.sv
// cohort_gearbox_slot_buf
// NUM_SLOTS x FRAME_W frame storage.
//   clk, rst_n          : clock, synchronous active-low reset (zeroes all slots)
//   wr_en/wr_slot/wr_beat/wr_data : write one IN_W beat into a slot
//   clr_en/clr_slot     : zero a whole slot (applied before a same-cycle write)
//   rd_slot/rd_beat     : combinational OUT_W slice read -> rd_data
// Beats are little-endian: beat k occupies bits [k*W +: W].
module cohort_gearbox_slot_buf #(
    parameter int IN_W      = 64,
    parameter int OUT_W     = 32,
    parameter int FRAME_W   = 128,
    parameter int NUM_SLOTS = 2,
    parameter int SLOT_W    = 1,
    parameter int IB_W      = 1,
    parameter int OB_W      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_slot,
    input  logic [IB_W-1:0]   wr_beat,
    input  logic [IN_W-1:0]   wr_data,
    input  logic              clr_en,
    input  logic [SLOT_W-1:0] clr_slot,
    input  logic [SLOT_W-1:0] rd_slot,
    input  logic [OB_W-1:0]   rd_beat,
    output logic [OUT_W-1:0]  rd_data
);

    logic [FRAME_W-1:0] mem [NUM_SLOTS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (clr_en) begin
                mem[clr_slot] <= '0;
            end
            if (wr_en) begin
                mem[wr_slot][int'(wr_beat) * IN_W +: IN_W] <= wr_data;
            end
        end
    end

    assign rd_data = mem[rd_slot][int'(rd_beat) * OUT_W +: OUT_W];

endmodule

// File: rtl/cohort_gearbox.sv
// cohort_gearbox
// Streaming width converter IN_W -> OUT_W through FRAME_W-wide frame slots
// (ping-pong when NUM_SLOTS=2). Frames may be terminated early with in_last;
// the unwritten tail reads as zero and the drain stops after
// ceil(fill_beats*IN_W/OUT_W) beats, flagging the final one with out_last.
//
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   in_valid, in_ready, in_data, in_last     : input beat channel
//   out_valid, out_ready, out_data, out_last : output beat channel
//   stat_frames, stat_in_stall      : counters, only when
//                                     COHORT_GEARBOX_STATS_EN is defined
//
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high. valid never waits on ready; once raised, valid and the payload
// hold until the transfer. in_ready comes from registered state only.
module cohort_gearbox #(
    parameter int IN_W      = 64,
    parameter int OUT_W     = 32,
    parameter int FRAME_W   = 128,
    parameter int NUM_SLOTS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last
`ifdef COHORT_GEARBOX_STATS_EN
    ,
    output logic [31:0]      stat_frames,
    output logic [31:0]      stat_in_stall
`endif
);
    import cohort_gearbox_pkg::*;

    localparam int IN_BEATS  = beats(FRAME_W, IN_W);
    localparam int OUT_BEATS = beats(FRAME_W, OUT_W);
    localparam int SLOT_W    = idx_w(NUM_SLOTS);
    localparam int IB_W      = idx_w(IN_BEATS);
    localparam int OB_W      = idx_w(OUT_BEATS);

    if (!params_legal(IN_W, OUT_W, FRAME_W, NUM_SLOTS)) begin : g_illegal
        $fatal(1, "cohort_gearbox: illegal IN_W/OUT_W/FRAME_W/NUM_SLOTS");
    end

    logic [SLOT_W-1:0] wr_ptr, rd_ptr;
    logic [IB_W-1:0]   in_cnt;
    logic [OB_W-1:0]   out_cnt;
    logic [1:0]        commit_cnt, commit_cnt_next;
    logic              in_ready_q;
    slot_meta_t        meta [NUM_SLOTS];

    logic in_fire, commit, out_fire, release_slot;
    int   drain_beats;

    assign in_ready = in_ready_q;

    always_comb begin
        in_fire      = in_valid && in_ready_q;
        commit       = in_fire && ((int'(in_cnt) == IN_BEATS - 1) || in_last);
        drain_beats  = ceil_div(int'(meta[rd_ptr].fill_beats) * IN_W, OUT_W);
        // Slots commit and release in order, so the slot under rd_ptr is
        // committed exactly when the count is non-zero.
        out_valid    = (commit_cnt != 2'd0) && meta[rd_ptr].committed;
        out_last     = out_valid && (int'(out_cnt) == drain_beats - 1);
        out_fire     = out_valid && out_ready;
        release_slot = out_fire && out_last;
        commit_cnt_next = commit_cnt;
        if (commit && !release_slot) begin
            commit_cnt_next = commit_cnt + 2'd1;
        end else if (!commit && release_slot) begin
            commit_cnt_next = commit_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            commit_cnt <= '0;
            in_ready_q <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                meta[i] <= '0;
            end
        end else begin
            commit_cnt <= commit_cnt_next;
            // Registered so in_ready reflects the post-update slot count.
            in_ready_q <= (int'(commit_cnt_next) < NUM_SLOTS);

            if (in_fire) begin
                if (commit) begin
                    in_cnt <= '0;
                    wr_ptr <= (int'(wr_ptr) == NUM_SLOTS - 1) ? '0 : wr_ptr + 1'b1;
                end else begin
                    in_cnt <= in_cnt + 1'b1;
                end
            end

            if (out_fire) begin
                if (release_slot) begin
                    out_cnt <= '0;
                    rd_ptr  <= (int'(rd_ptr) == NUM_SLOTS - 1) ? '0 : rd_ptr + 1'b1;
                end else begin
                    out_cnt <= out_cnt + 1'b1;
                end
            end

            // Fill and drain slots differ whenever both happen in one cycle.
            if (release_slot) begin
                meta[rd_ptr] <= '0;
            end
            if (commit) begin
                meta[wr_ptr] <= '{committed: 1'b1,
                                  fill_beats: CNT_W'(int'(in_cnt) + 1)};
            end
        end
    end

    cohort_gearbox_slot_buf #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .FRAME_W   (FRAME_W),
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W),
        .IB_W      (IB_W),
        .OB_W      (OB_W)
    ) u_slot_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (in_fire),
        .wr_slot  (wr_ptr),
        .wr_beat  (in_cnt),
        .wr_data  (in_data),
        .clr_en   (release_slot),
        .clr_slot (rd_ptr),
        .rd_slot  (rd_ptr),
        .rd_beat  (out_cnt),
        .rd_data  (out_data)
    );

`ifdef COHORT_GEARBOX_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_frames   <= '0;
            stat_in_stall <= '0;
        end else begin
            if (release_slot) begin
                stat_frames <= stat_frames + 32'd1;
            end
            if (in_valid && !in_ready_q) begin
                stat_in_stall <= stat_in_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cohort_gearbox.sv
`timescale 1ns/1ps
module tb_cohort_gearbox;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    // DUT a: defaults 64 -> 32, frame 128, two slots
    logic        a_in_valid, a_in_ready, a_in_last;
    logic [63:0] a_in_data;
    logic        a_out_valid, a_out_ready, a_out_last;
    logic [31:0] a_out_data;
    // DUT b: 32 -> 128, frame 128
    logic         b_in_valid, b_in_ready, b_in_last;
    logic [31:0]  b_in_data;
    logic         b_out_valid, b_out_ready, b_out_last;
    logic [127:0] b_out_data;
`ifdef COHORT_GEARBOX_STATS_EN
    logic [31:0] a_stat_frames, a_stat_in_stall, b_stat_frames, b_stat_in_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard queues
    logic [31:0]  exp_q[$];
    logic [127:0] wexp_q[$];
    logic         exp_last_q[$];

    cohort_gearbox u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_last   (a_in_last),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_last  (a_out_last)
`ifdef COHORT_GEARBOX_STATS_EN
        ,
        .stat_frames   (a_stat_frames),
        .stat_in_stall (a_stat_in_stall)
`endif
    );

    cohort_gearbox #(.IN_W(32), .OUT_W(128), .FRAME_W(128), .NUM_SLOTS(2)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_last   (b_in_last),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_last  (b_out_last)
`ifdef COHORT_GEARBOX_STATS_EN
        ,
        .stat_frames   (b_stat_frames),
        .stat_in_stall (b_stat_in_stall)
`endif
    );

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        a_in_valid = 1'b0; a_in_last = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_last = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    endtask

    // Present one beat at a negedge and return at the negedge after it transfers.
    task automatic drive_a(input logic [63:0] d, input logic l);
        int cyc = 0;
        a_in_valid = 1'b1; a_in_data = d; a_in_last = l;
        while (!a_in_ready && cyc < 50) begin
            @(negedge clk); cyc++;
        end
        n_checks++;
        if (a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drive_a_accept: in_ready=%b want 1 within 50 cycles", a_in_ready);
        end
        @(negedge clk);
        a_in_valid = 1'b0; a_in_last = 1'b0;
    endtask

    task automatic drive_b(input logic [31:0] d, input logic l);
        int cyc = 0;
        b_in_valid = 1'b1; b_in_data = d; b_in_last = l;
        while (!b_in_ready && cyc < 50) begin
            @(negedge clk); cyc++;
        end
        n_checks++;
        if (b_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drive_b_accept: in_ready=%b want 1 within 50 cycles", b_in_ready);
        end
        @(negedge clk);
        b_in_valid = 1'b0; b_in_last = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk); rst_n = 1'b0; idle_inputs();
        @(negedge clk);
        n_checks++;
        if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got a=%b b=%b want 0", a_in_ready, b_in_ready);
        end
        n_checks++;
        if (a_out_valid !== 1'b0 || a_out_last !== 1'b0 || a_out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out_a: got v=%b l=%b d=%h want 0/0/0", a_out_valid, a_out_last, a_out_data);
        end
        n_checks++;
        if (b_out_valid !== 1'b0 || b_out_last !== 1'b0 || b_out_data !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_out_b: got v=%b l=%b d=%h want 0/0/0", b_out_valid, b_out_last, b_out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_in_ready: got a=%b b=%b want 1", a_in_ready, b_in_ready);
        end
        n_checks++;
        if (a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_out_valid: got %b want 0", a_out_valid);
        end
    endtask

    // Drain DUT a against exp_q/exp_last_q, checking at each negedge.
    task automatic drain_a(input string name, input int budget);
        int cyc = 0;
        int got = 0;
        logic [31:0] want;
        logic wl;
        a_out_ready = 1'b1;
        while (exp_q.size() > 0 && cyc < budget) begin
            if (a_out_valid) begin
                want = exp_q.pop_front(); wl = exp_last_q.pop_front();
                n_checks++;
                if (a_out_data !== want || a_out_last !== wl) begin
                    n_fail++;
                    $display("FAIL %s_beat%0d: got %h last=%b want %h last=%b",
                             name, got, a_out_data, a_out_last, want, wl);
                end
                got++;
            end
            @(negedge clk); cyc++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d beats missing, want 0", name, exp_q.size());
            exp_q.delete(); exp_last_q.delete();
        end
        n_checks++;
        if (a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_extra_beat: out_valid=%b want 0", name, a_out_valid);
        end
    endtask

    task automatic test_basic();
        exp_q = '{32'h3333_4444, 32'h1111_2222, 32'h7777_8888, 32'h5555_6666};
        exp_last_q = '{1'b0, 1'b0, 1'b0, 1'b1};
        a_out_ready = 1'b1;
        drive_a(64'h1111_2222_3333_4444, 1'b0);
        n_checks++;
        if (a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early_valid: got %b want 0", a_out_valid);
        end
        drive_a(64'h5555_6666_7777_8888, 1'b0);
        n_checks++;
        if (a_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: out_valid=%b want 1 one cycle after commit", a_out_valid);
        end
        drain_a("basic", 20);
    endtask

    task automatic test_last();
        exp_q = '{32'hCAFE_F00D, 32'hDEAD_BEEF};
        exp_last_q = '{1'b0, 1'b1};
        drive_a(64'hDEAD_BEEF_CAFE_F00D, 1'b1);
        drain_a("short", 20);
        // Following full frame must be unaffected by the short one.
        exp_q = '{32'h89AB_CDEF, 32'h0123_4567, 32'h7654_3210, 32'hFEDC_BA98};
        exp_last_q = '{1'b0, 1'b0, 1'b0, 1'b1};
        drive_a(64'h0123_4567_89AB_CDEF, 1'b0);
        drive_a(64'hFEDC_BA98_7654_3210, 1'b0);
        drain_a("after_short", 20);
    endtask

    task automatic test_backpressure();
        logic [63:0] beats [6];
        int acc = 0;
        int cyc = 0;
        int got = 0;
        logic will;
        logic [31:0] want;
        logic wl;
        beats = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                  64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                  64'hAAAA_0001_AAAA_0000, 64'hAAAA_0003_AAAA_0002};
        exp_q = '{32'h3333_4444, 32'h1111_2222, 32'h7777_8888, 32'h5555_6666,
                  32'h89AB_CDEF, 32'h0123_4567, 32'h7654_3210, 32'hFEDC_BA98,
                  32'hAAAA_0000, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003};
        exp_last_q = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
        a_out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a_in_valid = (acc < 6); a_in_data = beats[(acc < 6) ? acc : 0];
            will = a_in_valid && a_in_ready;
            if (acc == 4) begin
                n_checks++;
                if (a_in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_in_ready_cyc%0d: got %b want 0", i, a_in_ready);
                end
                n_checks++;
                if (a_out_valid !== 1'b1 || a_out_data !== 32'h3333_4444 || a_out_last !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_hold_cyc%0d: got v=%b d=%h l=%b want 1/33334444/0",
                             i, a_out_valid, a_out_data, a_out_last);
                end
            end
            @(negedge clk);
            if (will) acc++;
        end
        n_checks++;
        if (acc != 4) begin
            n_fail++;
            $display("FAIL bp_accepted: got %0d beats want 4", acc);
        end
        a_out_ready = 1'b1;
        while (exp_q.size() > 0 && cyc < 60) begin
            a_in_valid = (acc < 6); a_in_data = beats[(acc < 6) ? acc : 0];
            will = a_in_valid && a_in_ready;
            if (a_out_valid) begin
                want = exp_q.pop_front(); wl = exp_last_q.pop_front();
                n_checks++;
                if (a_out_data !== want || a_out_last !== wl) begin
                    n_fail++;
                    $display("FAIL bp_beat%0d: got %h last=%b want %h last=%b",
                             got, a_out_data, a_out_last, want, wl);
                end
                got++;
            end
            @(negedge clk); cyc++;
            if (will) acc++;
        end
        a_in_valid = 1'b0;
        n_checks++;
        if (exp_q.size() != 0 || acc != 6) begin
            n_fail++;
            $display("FAIL bp_timeout: %0d beats missing, %0d accepted, want 0 and 6", exp_q.size(), acc);
            exp_q.delete(); exp_last_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int cyc = 0;
        int got = 0;
        int gaps = 0;
        logic started = 1'b0;
        logic will;
        logic [31:0] want;
        logic wl;
        for (int j = 0; j < 32; j++) begin
            exp_q.push_back(32'hC000_0000 + 32'(j));
            exp_last_q.push_back((j % 4) == 3);
        end
        a_out_ready = 1'b1;
        while (exp_q.size() > 0 && cyc < 120) begin
            a_in_valid = (acc < 16);
            a_in_data  = {32'hC000_0000 + 32'(2 * acc + 1), 32'hC000_0000 + 32'(2 * acc)};
            will = a_in_valid && a_in_ready;
            if (a_out_valid) started = 1'b1;
            if (started && !a_out_valid) gaps++;
            if (a_out_valid) begin
                want = exp_q.pop_front(); wl = exp_last_q.pop_front();
                n_checks++;
                if (a_out_data !== want || a_out_last !== wl) begin
                    n_fail++;
                    $display("FAIL b2b_beat%0d: got %h last=%b want %h last=%b",
                             got, a_out_data, a_out_last, want, wl);
                end
                got++;
            end
            @(negedge clk); cyc++;
            if (will) acc++;
        end
        a_in_valid = 1'b0;
        n_checks++;
        if (gaps != 0) begin
            n_fail++;
            $display("FAIL b2b_gaps: got %0d idle cycles want 0", gaps);
        end
        n_checks++;
        if (exp_q.size() != 0 || got != 32) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d beats want 32", got);
            exp_q.delete(); exp_last_q.delete();
        end
    endtask

    task automatic test_reset_mid_frame();
        drive_a(64'h9999_9999_9999_9999, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_in_reset: got ready=%b valid=%b want 0/0", a_in_ready, a_out_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_after: got valid=%b ready=%b want 0/1", a_out_valid, a_in_ready);
        end
        exp_q = '{32'h3333_4444, 32'h1111_2222, 32'h7777_8888, 32'h5555_6666};
        exp_last_q = '{1'b0, 1'b0, 1'b0, 1'b1};
        drive_a(64'h1111_2222_3333_4444, 1'b0);
        drive_a(64'h5555_6666_7777_8888, 1'b0);
        drain_a("midrst", 20);
    endtask

    task automatic test_wide();
        wexp_q = '{{128{1'b1}}, {128{1'b1}}, 128'h0000_0000_0000_0003_0000_0002_0000_0001};
        exp_last_q = '{1'b1, 1'b1, 1'b1};
        b_out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) drive_b(32'hFFFF_FFFF, 1'b0);
                drive_b(32'h1, 1'b0);
                drive_b(32'h2, 1'b0);
                drive_b(32'h3, 1'b1);
            end
            begin
                int cyc = 0;
                int got = 0;
                logic [127:0] want;
                logic wl;
                while (wexp_q.size() > 0 && cyc < 80) begin
                    if (b_out_valid) begin
                        want = wexp_q.pop_front(); wl = exp_last_q.pop_front();
                        n_checks++;
                        if (b_out_data !== want || b_out_last !== wl) begin
                            n_fail++;
                            $display("FAIL wide_beat%0d: got %h last=%b want %h last=%b",
                                     got, b_out_data, b_out_last, want, wl);
                        end
                        got++;
                    end
                    @(negedge clk); cyc++;
                end
            end
        join
        n_checks++;
        if (wexp_q.size() != 0 || b_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_count: %0d beats missing, out_valid=%b, want 0/0", wexp_q.size(), b_out_valid);
            wexp_q.delete(); exp_last_q.delete();
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_last();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 ns");
        $fatal(1, "watchdog");
    end

endmodule
